// File: rtl/sobol_bitstream_gen.sv
// Converts a latched binary operand into a 2**INWD-bit unary stream by comparing it with Sobol samples.
// Optional macro ONES_COUNT_EN adds the ones_cnt output (running count of accepted 1-bits).
module sobol_bitstream_gen #(
  parameter int unsigned INWD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [INWD-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [INWD-1:0] rng_in,
  output logic            rng_en,
  output logic            bit_out,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            bit_last
`ifdef ONES_COUNT_EN
  ,
  output logic [INWD:0]   ones_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [INWD-1:0] CNT_MAX = '1;

  state_t          state;
  logic [INWD-1:0] val_q;
  logic [INWD-1:0] cnt;
  logic [INWD-1:0] cnt_nxt;
  logic            accept;

  // bit_out follows rng_in directly; upstream holds rng_in while rng_en is low
  assign accept  = bit_valid & bit_ready;
  assign rng_en  = accept;
  assign bit_out = bit_valid & (rng_in < val_q);
  assign cnt_nxt = INWD'(cnt + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      val_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= RUN;
            in_ready  <= 1'b0;
            bit_valid <= 1'b1;
            bit_last  <= (CNT_MAX == '0);
            val_q     <= in_data;
            cnt       <= '0;
          end
        end
        RUN: begin
          if (bit_ready) begin
            cnt      <= cnt_nxt;
            bit_last <= (cnt_nxt == CNT_MAX);
            // cnt wraps to zero exactly as the final bit is taken
            if (cnt == CNT_MAX) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              bit_valid <= 1'b0;
              bit_last  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          bit_valid <= 1'b0;
          bit_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ONES_COUNT_EN
  // Counts accepted ones; value persists in IDLE until the next operand latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (in_ready && in_valid) begin
      ones_cnt <= '0;
    end else if (accept && bit_out) begin
      ones_cnt <= (INWD + 1)'(ones_cnt + 1'b1);
    end
  end
`endif

endmodule
